// File: rtl/hazard_tracker.sv
// hazard_tracker: E/M/W writer records -> D-stage stall + comparator forward selects (in: clk, reset async active-low, validD, rsD/rtD, tuseRsD/tuseRtD, dstD, kindD; out: MCMP1D, MCMP2D, stall, stallCnt)
module hazard_tracker (
    input  logic        clk,
    input  logic        reset,
    input  logic        validD,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic [1:0]  tuseRsD,
    input  logic [1:0]  tuseRtD,
    input  logic [4:0]  dstD,
    input  logic [1:0]  kindD,
    output logic [2:0]  MCMP1D,
    output logic [2:0]  MCMP2D,
    output logic        stall,
    output logic [15:0] stallCnt
);
    localparam logic [1:0] ALU = 2'd1, LOAD = 2'd2, LINK = 2'd3;
    typedef struct packed {
        logic       v;
        logic [4:0] dst;
        logic [1:0] kind;
        logic [1:0] tnew;
    } rec_t;
    rec_t e_q, m_q, w_q;
    logic [3:0] rs_res, rt_res;
    function automatic rec_t age(input rec_t r);
        age = r;
        age.tnew = r.tnew == 2'd0 ? 2'd0 : r.tnew - 2'd1;
    endfunction
    function automatic logic [3:0] resolve(input logic [4:0] r, input logic [1:0] tuse,
                                           input rec_t e, input rec_t m, input rec_t w);
        logic [1:0] stage;
        rec_t h;
        logic [2:0] sel;
        stage = (e.v && e.dst == r) ? 2'd1 : (m.v && m.dst == r) ? 2'd2 : (w.v && w.dst == r) ? 2'd3 : 2'd0;
        h = stage == 2'd1 ? e : stage == 2'd2 ? m : w;
        sel = stage == 2'd1 ? (h.kind == LINK ? 3'd6 : 3'd0) :
              stage == 2'd2 ? (h.kind == ALU ? 3'd3 : h.kind == LINK ? 3'd5 : 3'd0) :
              (h.kind == LOAD ? 3'd1 : h.kind == ALU ? 3'd2 : h.kind == LINK ? 3'd4 : 3'd0);
        resolve = (r == 5'd0 || tuse == 2'd3 || stage == 2'd0) ? 4'd0 :
                  h.tnew > tuse ? 4'b1000 :
                  h.tnew != 2'd0 ? 4'd0 : {1'b0, sel};
    endfunction
    always_comb begin
        rs_res = resolve(rsD, tuseRsD, e_q, m_q, w_q);
        rt_res = resolve(rtD, tuseRtD, e_q, m_q, w_q);
        stall  = validD && (rs_res[3] || rt_res[3]);
        MCMP1D = validD ? rs_res[2:0] : 3'd0;
        MCMP2D = validD ? rt_res[2:0] : 3'd0;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q      <= '0;
            m_q      <= '0;
            w_q      <= '0;
            stallCnt <= '0;
        end else begin
            e_q <= stall ? rec_t'(0) : rec_t'{v: validD && dstD != 5'd0 && kindD != 2'd0, dst: dstD, kind: kindD,
                                             tnew: kindD == ALU ? 2'd1 : kindD == LOAD ? 2'd2 : 2'd0};
            m_q <= age(e_q);
            w_q <= age(m_q);
            if (stall && stallCnt != 16'hFFFF)
                stallCnt <= stallCnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker: directed scenarios plus randomized traffic against a pipeline-slot reference model
module tb_hazard_tracker;
    logic        clk = 0, reset = 0, validD = 0;
    logic [4:0]  rsD = 0, rtD = 0, dstD = 0;
    logic [1:0]  tuseRsD = 3, tuseRtD = 3, kindD = 0;
    logic [2:0]  MCMP1D, MCMP2D;
    logic        stall;
    logic [15:0] stallCnt;
    int n_chk = 0, n_pass = 0;

    hazard_tracker dut (
        .clk(clk), .reset(reset), .validD(validD), .rsD(rsD), .rtD(rtD),
        .tuseRsD(tuseRsD), .tuseRtD(tuseRtD), .dstD(dstD), .kindD(kindD),
        .MCMP1D(MCMP1D), .MCMP2D(MCMP2D), .stall(stall), .stallCnt(stallCnt)
    );

    always #5 clk = ~clk;

    // Reference model: slot 0 = E, 1 = M, 2 = W; readiness derived from producer latency and slot position.
    typedef struct {bit v; int dst; int kind;} slot_t;
    slot_t pipe[3];
    int m_cnt;
    int sel_tab[3][4] = '{'{0, 0, 0, 6}, '{0, 3, 0, 5}, '{0, 2, 1, 4}};

    function automatic int lat(input int k);
        return k == 1 ? 1 : k == 2 ? 2 : 0;
    endfunction

    task automatic model_clear();
        for (int p = 0; p < 3; p++) pipe[p] = '{0, 0, 0};
        m_cnt = 0;
    endtask

    task automatic model_op(input int r, input int tu, output logic st, output logic [2:0] sel);
        int tn;
        st = 0;
        sel = 0;
        if (!validD || r == 0 || tu == 3) return;
        for (int p = 0; p < 3; p++) begin
            if (pipe[p].v && pipe[p].dst == r) begin
                tn = lat(pipe[p].kind) - p;
                if (tn < 0) tn = 0;
                if (tn > tu) st = 1;
                else if (tn == 0) sel = 3'(sel_tab[p][pipe[p].kind]);
                return;
            end
        end
    endtask

    task automatic model_eval(output logic st, output logic [2:0] s1, output logic [2:0] s2);
        logic a, b;
        model_op(int'(rsD), int'(tuseRsD), a, s1);
        model_op(int'(rtD), int'(tuseRtD), b, s2);
        st = a | b;
    endtask

    function automatic logic [15:0] exp_cnt();
        return m_cnt > 65535 ? 16'hFFFF : 16'(m_cnt);
    endfunction

    task automatic model_adv();
        logic st;
        logic [2:0] s1, s2;
        model_eval(st, s1, s2);
        if (st) m_cnt++;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0].v = !st && validD && dstD != 0 && kindD != 0;
        pipe[0].dst = int'(dstD);
        pipe[0].kind = int'(kindD);
    endtask

    task automatic set_d(input int v, input int rs, input int trs, input int rt, input int trt, input int dst, input int kind);
        validD = v[0]; rsD = 5'(rs); tuseRsD = 2'(trs); rtD = 5'(rt); tuseRtD = 2'(trt); dstD = 5'(dst); kindD = 2'(kind);
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_adv();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 0;
        set_d(0, 0, 3, 0, 3, 0, 0);
        model_clear();
        @(negedge clk);
        reset = 1;
    endtask

    task automatic test_reset();
        set_d(1, 5, 0, 5, 0, 5, 2);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++; if (stall !== 1'b0) $display("FAIL rst_stall: got %0d want 0", stall); else n_pass++;
        n_chk++; if (MCMP1D !== 3'd0) $display("FAIL rst_sel1: got %0d want 0", MCMP1D); else n_pass++;
        n_chk++; if (MCMP2D !== 3'd0) $display("FAIL rst_sel2: got %0d want 0", MCMP2D); else n_pass++;
        n_chk++; if (stallCnt !== 16'd0) $display("FAIL rst_cnt: got %0d want 0", stallCnt); else n_pass++;
        reset = 1;
        clk_step();
        set_d(1, 5, 0, 0, 3, 0, 0);
        #1;
        n_chk++; if (stall !== 1'b1) $display("FAIL rst_first_load: got %0d want 1", stall); else n_pass++;
    endtask

    task automatic test_alu();
        do_reset();
        set_d(1, 0, 3, 0, 3, 8, 1);
        clk_step();
        set_d(1, 8, 0, 0, 3, 0, 0);
        #1;
        n_chk++; if (stall !== 1'b1) $display("FAIL alu_c1_stall: got %0d want 1", stall); else n_pass++;
        n_chk++; if (MCMP1D !== 3'd0) $display("FAIL alu_c1_sel: got %0d want 0", MCMP1D); else n_pass++;
        clk_step();
        #1;
        n_chk++; if (stall !== 1'b0) $display("FAIL alu_c2_stall: got %0d want 0", stall); else n_pass++;
        n_chk++; if (MCMP1D !== 3'd3) $display("FAIL alu_c2_sel: got %0d want 3", MCMP1D); else n_pass++;
        n_chk++; if (stallCnt !== 16'd1) $display("FAIL alu_cnt: got %0d want 1", stallCnt); else n_pass++;
    endtask

    task automatic test_load();
        do_reset();
        set_d(1, 0, 3, 0, 3, 9, 2);
        clk_step();
        set_d(1, 0, 3, 9, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_chk++; if (stall !== 1'b1) $display("FAIL load_stall%0d: got %0d want 1", i, stall); else n_pass++;
            clk_step();
        end
        #1;
        n_chk++; if (stall !== 1'b0) $display("FAIL load_release: got %0d want 0", stall); else n_pass++;
        n_chk++; if (MCMP2D !== 3'd1) $display("FAIL load_sel: got %0d want 1", MCMP2D); else n_pass++;
        n_chk++; if (stallCnt !== 16'd2) $display("FAIL load_cnt: got %0d want 2", stallCnt); else n_pass++;
    endtask

    task automatic test_link();
        do_reset();
        set_d(1, 0, 3, 0, 3, 31, 3);
        clk_step();
        set_d(1, 31, 0, 0, 3, 0, 0);
        #1;
        n_chk++; if (stall !== 1'b0) $display("FAIL link_stall: got %0d want 0", stall); else n_pass++;
        n_chk++; if (MCMP1D !== 3'd6) $display("FAIL link_selE: got %0d want 6", MCMP1D); else n_pass++;
        do_reset();
        set_d(1, 0, 3, 0, 3, 9, 2);
        clk_step();
        set_d(1, 0, 3, 0, 3, 31, 3);
        clk_step();
        set_d(1, 31, 0, 9, 0, 0, 0);
        #1;
        n_chk++; if (stall !== 1'b1) $display("FAIL link_held_stall: got %0d want 1", stall); else n_pass++;
        n_chk++; if (MCMP1D !== 3'd6) $display("FAIL link_held_selE: got %0d want 6", MCMP1D); else n_pass++;
        clk_step();
        #1;
        n_chk++; if (stall !== 1'b0) $display("FAIL link_m_stall: got %0d want 0", stall); else n_pass++;
        n_chk++; if (MCMP1D !== 3'd5) $display("FAIL link_selM: got %0d want 5", MCMP1D); else n_pass++;
        n_chk++; if (MCMP2D !== 3'd1) $display("FAIL link_loadW: got %0d want 1", MCMP2D); else n_pass++;
    endtask

    task automatic test_priority();
        do_reset();
        set_d(1, 0, 3, 0, 3, 5, 1);
        clk_step();
        set_d(1, 0, 3, 0, 3, 5, 2);
        clk_step();
        set_d(1, 5, 1, 0, 3, 0, 0);
        #1;
        n_chk++; if (stall !== 1'b1) $display("FAIL prio_stall: got %0d want 1", stall); else n_pass++;
        n_chk++; if (MCMP1D !== 3'd0) $display("FAIL prio_sel: got %0d want 0", MCMP1D); else n_pass++;
        clk_step();
        #1;
        n_chk++; if (stall !== 1'b0) $display("FAIL prio_late_stall: got %0d want 0", stall); else n_pass++;
        n_chk++; if (MCMP1D !== 3'd0) $display("FAIL prio_late_sel: got %0d want 0", MCMP1D); else n_pass++;
    endtask

    task automatic test_zero_unused();
        do_reset();
        set_d(1, 0, 3, 0, 3, 0, 2);
        clk_step();
        set_d(1, 0, 0, 0, 0, 0, 0);
        #1;
        n_chk++; if (stall !== 1'b0 || MCMP1D !== 3'd0) $display("FAIL zero_reg: got stall=%0d sel=%0d want 0/0", stall, MCMP1D); else n_pass++;
        do_reset();
        set_d(1, 0, 3, 0, 3, 7, 2);
        clk_step();
        set_d(1, 7, 3, 7, 3, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (stall !== 1'b0 || MCMP1D !== 3'd0 || MCMP2D !== 3'd0)
                $display("FAIL unused_%0d: got stall=%0d sel1=%0d sel2=%0d want 0/0/0", i, stall, MCMP1D, MCMP2D); else n_pass++;
            clk_step();
        end
        do_reset();
        set_d(1, 0, 3, 0, 3, 7, 2);
        clk_step();
        set_d(0, 7, 0, 7, 0, 0, 0);
        #1;
        n_chk++; if (stall !== 1'b0) $display("FAIL bubble_stall: got %0d want 0", stall); else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_d(1, 0, 3, 0, 3, 9, 2);
        clk_step();
        set_d(1, 0, 3, 9, 0, 0, 0);
        clk_step();
        #1;
        n_chk++; if (stall !== 1'b1 || stallCnt !== 16'd1) $display("FAIL mid_pre: got stall=%0d cnt=%0d want 1/1", stall, stallCnt); else n_pass++;
        #1 reset = 0;
        #1;
        n_chk++; if (stall !== 1'b0) $display("FAIL mid_stall_drop: got %0d want 0", stall); else n_pass++;
        n_chk++; if (stallCnt !== 16'd0) $display("FAIL mid_cnt_clear: got %0d want 0", stallCnt); else n_pass++;
        model_clear();
        @(negedge clk);
        reset = 1;
        #1;
        n_chk++; if (stall !== 1'b0 || MCMP2D !== 3'd0) $display("FAIL mid_lost: got stall=%0d sel=%0d want 0/0", stall, MCMP2D); else n_pass++;
    endtask

    task automatic test_random();
        logic st;
        logic [2:0] s1, s2;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_d(($urandom % 8) != 0, $urandom % 4, $urandom % 4, $urandom % 4, $urandom % 4, $urandom % 4, $urandom % 4);
            #1;
            model_eval(st, s1, s2);
            n_chk++; if (stall !== st) $display("FAIL rnd_stall@%0d: got %0d want %0d", i, stall, st); else n_pass++;
            n_chk++; if (MCMP1D !== s1) $display("FAIL rnd_sel1@%0d: got %0d want %0d", i, MCMP1D, s1); else n_pass++;
            n_chk++; if (MCMP2D !== s2) $display("FAIL rnd_sel2@%0d: got %0d want %0d", i, MCMP2D, s2); else n_pass++;
            n_chk++; if (stallCnt !== exp_cnt()) $display("FAIL rnd_cnt@%0d: got %0d want %0d", i, stallCnt, exp_cnt()); else n_pass++;
            clk_step();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_d(1, 9, 0, 0, 3, 9, 2);
        for (int i = 0; i < 98310; i++) begin
            clk_step();
            if (m_cnt >= 65533) begin
                #1;
                n_chk++; if (stallCnt !== exp_cnt()) $display("FAIL sat_cnt@%0d: got %0h want %0h", m_cnt, stallCnt, exp_cnt()); else n_pass++;
            end
        end
        #1;
        n_chk++; if (stallCnt !== 16'hFFFF) $display("FAIL sat_final: got %0h want ffff (model stalls %0d)", stallCnt, m_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_link();
        test_priority();
        test_zero_unused();
        test_reset_mid_stall();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
